// File: rtl/sa_cache_pkg.sv
// Shared sa_cache definitions: address field widths and the miss-controller state encoding.
`timescale 1ns/1ps
package sa_cache_pkg;

    localparam int unsigned TAG_W    = 18;
    localparam int unsigned INDEX_W  = 8;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned ADDR_W   = TAG_W + INDEX_W + OFFSET_W;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WB   = 3'd1,
        ST_FILL = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } miss_state_e;

endpackage

// File: rtl/sa_miss_timer.sv
// Memory-ack wait counter: cleared on entry to a wait state, counts un-acked cycles, flags TIMEOUT.
`timescale 1ns/1ps
module sa_miss_timer #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    assign expired = (count == TIMEOUT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// sa_cache refill sequencer: optional write-back, line fill, one-cycle response pulse.
// Define SA_MISS_CTRL_STATS_EN to build the miss/write-back statistics counters.
`timescale 1ns/1ps
module sa_cache_miss_ctrl #(
    parameter int unsigned ADDR_W    = sa_cache_pkg::ADDR_W,
    parameter int unsigned DATA_W    = sa_cache_pkg::DATA_W,
    parameter int unsigned OFFSET_W  = sa_cache_pkg::OFFSET_W,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cache_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              i_evict,
    input  logic [ADDR_W-1:0] i_evict_addr,
    input  logic [DATA_W-1:0] i_evict_data,
    output logic [DATA_W-1:0] o_memory_line,
    output logic              o_memory_response,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_timeout,
    output logic [15:0]       o_miss_cnt,
    output logic [15:0]       o_evict_cnt
);

    import sa_cache_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    miss_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W-1:0] evict_addr_q, evict_addr_d;
    logic [DATA_W-1:0] evict_data_q, evict_data_d;
    logic              accept, timer_clear, timer_en, expired;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: if (i_cache_miss) begin
                accept      = 1'b1;
                timer_clear = 1'b1;
                state_d     = i_evict ? ST_WB : ST_FILL;
            end
            ST_WB: if (i_mem_ack) begin
                timer_clear = 1'b1;
                state_d     = ST_FILL;
            end else if (expired) begin
                state_d = ST_ERR;
            end
            ST_FILL: if (i_mem_ack) state_d = ST_RESP;
                     else if (expired) state_d = ST_ERR;
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    assign timer_en     = ((state_q == ST_WB) || (state_q == ST_FILL)) && !i_mem_ack;
    assign fill_addr_d  = accept ? (i_miss_addr & LINE_MASK) : fill_addr_q;
    assign evict_addr_d = accept ? i_evict_addr : evict_addr_q;
    assign evict_data_d = accept ? i_evict_data : evict_data_q;
    assign o_stall      = (state_q != ST_IDLE);

    sa_miss_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    // Memory-side outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_IDLE;
            fill_addr_q       <= '0;
            evict_addr_q      <= '0;
            evict_data_q      <= '0;
            o_mem_req         <= 1'b0;
            o_mem_we          <= 1'b0;
            o_mem_addr        <= '0;
            o_mem_wdata       <= '0;
            o_memory_line     <= '0;
            o_memory_response <= 1'b0;
            o_timeout         <= 1'b0;
        end else begin
            state_q           <= state_d;
            fill_addr_q       <= fill_addr_d;
            evict_addr_q      <= evict_addr_d;
            evict_data_q      <= evict_data_d;
            o_mem_req         <= (state_d == ST_WB) || (state_d == ST_FILL);
            o_mem_we          <= (state_d == ST_WB);
            if (state_d == ST_WB) begin
                o_mem_addr  <= evict_addr_d;
                o_mem_wdata <= evict_data_d;
            end else if (state_d == ST_FILL) begin
                o_mem_addr  <= fill_addr_d;
            end
            if ((state_q == ST_FILL) && i_mem_ack) begin
                o_memory_line <= i_mem_rdata;
            end
            o_memory_response <= (state_d == ST_RESP);
            o_timeout         <= (state_d == ST_ERR);
        end
    end

`ifdef SA_MISS_CTRL_STATS_EN
    logic wb_done;
    assign wb_done = (state_q == ST_WB) && i_mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_miss_cnt  <= '0;
            o_evict_cnt <= '0;
        end else begin
            if (accept && (o_miss_cnt != '1)) o_miss_cnt <= o_miss_cnt + 1'b1;
            if (wb_done && (o_evict_cnt != '1)) o_evict_cnt <= o_evict_cnt + 1'b1;
        end
    end
`else
    assign o_miss_cnt  = '0;
    assign o_evict_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Directed bench for sa_cache_miss_ctrl built with TIMEOUT = 4.
`timescale 1ns/1ps
module tb_sa_cache_miss_ctrl;

`ifdef SA_MISS_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cache_miss;
    logic [31:0] i_miss_addr;
    logic        i_evict;
    logic [31:0] i_evict_addr;
    logic [31:0] i_evict_data;
    logic [31:0] o_memory_line;
    logic        o_memory_response;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_timeout;
    logic [15:0] o_miss_cnt;
    logic [15:0] o_evict_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_cache_miss_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .OFFSET_W  (6),
        .TIMEOUT   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cache_miss      (i_cache_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_stall           (o_stall),
        .o_mem_req         (o_mem_req),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_ack         (i_mem_ack),
        .i_mem_rdata       (i_mem_rdata),
        .o_timeout         (o_timeout),
        .o_miss_cnt        (o_miss_cnt),
        .o_evict_cnt       (o_evict_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; i_cache_miss = 1'b0; i_miss_addr = '0; i_evict = 1'b0;
        i_evict_addr = '0; i_evict_data = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        tick(); tick();
        check("rst_req",   64'(o_mem_req), 64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_resp",  64'(o_memory_response), 64'd0);
        check("rst_tmo",   64'(o_timeout), 64'd0);
        check("rst_addr",  64'(o_mem_addr), 64'd0);
        check("rst_line",  64'(o_memory_line), 64'd0);
        check("rst_mcnt",  64'(o_miss_cnt), 64'd0);
        rst = 1'b1;
        tick();

        // clean miss, zero-wait memory
        i_cache_miss = 1'b1; i_miss_addr = 32'h0001_2345; i_evict = 1'b0;
        tick();
        check("clean_req",   64'(o_mem_req), 64'd1);
        check("clean_we",    64'(o_mem_we), 64'd0);
        check("clean_addr",  64'(o_mem_addr), 64'h0001_2340);
        check("clean_stall", 64'(o_stall), 64'd1);
        check("clean_early", 64'(o_memory_response), 64'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("clean_resp",  64'(o_memory_response), 64'd1);
        check("clean_line",  64'(o_memory_line), 64'hDEAD_BEEF);
        check("clean_reqlo", 64'(o_mem_req), 64'd0);
        i_cache_miss = 1'b0; i_mem_ack = 1'b0;
        tick();
        check("clean_pulse", 64'(o_memory_response), 64'd0);
        check("clean_idle",  64'(o_stall), 64'd0);

        // dirty miss, every ack delayed 3 cycles; inputs scrambled after accept
        i_cache_miss = 1'b1; i_miss_addr = 32'h0004_5678; i_evict = 1'b1;
        i_evict_addr = 32'h0000_0FC0; i_evict_data = 32'h1234_5678;
        tick();
        i_evict_addr = 32'hAAAA_AAAA; i_evict_data = 32'h5555_5555; i_miss_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            check("wb_req",   64'(o_mem_req), 64'd1);
            check("wb_we",    64'(o_mem_we), 64'd1);
            check("wb_addr",  64'(o_mem_addr), 64'h0000_0FC0);
            check("wb_wdata", 64'(o_mem_wdata), 64'h1234_5678);
            check("wb_stall", 64'(o_stall), 64'd1);
            if (i == 3) i_mem_ack = 1'b1;
            tick();
            i_mem_ack = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            check("fill_req",   64'(o_mem_req), 64'd1);
            check("fill_we",    64'(o_mem_we), 64'd0);
            check("fill_addr",  64'(o_mem_addr), 64'h0004_5640);
            check("fill_stall", 64'(o_stall), 64'd1);
            check("fill_resp",  64'(o_memory_response), 64'd0);
            if (i == 3) begin i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_F00D; end
            tick();
            i_mem_ack = 1'b0;
        end
        check("dirty_resp",  64'(o_memory_response), 64'd1);
        check("dirty_line",  64'(o_memory_line), 64'hCAFE_F00D);
        check("dirty_stall", 64'(o_stall), 64'd1);
        i_cache_miss = 1'b0;
        tick();
        check("dirty_idle", 64'(o_stall), 64'd0);

        // back-to-back: miss held high across RESP
        i_cache_miss = 1'b1; i_miss_addr = 32'h0000_0100; i_evict = 1'b0;
        tick();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_1111;
        tick();
        check("b2b_resp1", 64'(o_memory_response), 64'd1);
        i_mem_ack = 1'b0; i_miss_addr = 32'h0000_2047; i_evict = 1'b1;
        i_evict_addr = 32'h0000_3000; i_evict_data = 32'h0000_0055;
        tick();
        check("b2b_nodbl",  64'(o_memory_response), 64'd0);
        check("b2b_gapreq", 64'(o_mem_req), 64'd0);
        check("b2b_gap",    64'(o_stall), 64'd0);
        tick();
        check("b2b_wbreq",  64'(o_mem_req), 64'd1);
        check("b2b_wbwe",   64'(o_mem_we), 64'd1);
        check("b2b_wbaddr", 64'(o_mem_addr), 64'h0000_3000);
        check("b2b_noresp", 64'(o_memory_response), 64'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h2222_2222;
        tick();
        check("b2b_fillreq", 64'(o_mem_req), 64'd1);
        check("b2b_fillwe",  64'(o_mem_we), 64'd0);
        check("b2b_filladr", 64'(o_mem_addr), 64'h0000_2040);
        tick();
        check("b2b_resp2", 64'(o_memory_response), 64'd1);
        check("b2b_line2", 64'(o_memory_line), 64'h2222_2222);
        i_cache_miss = 1'b0; i_mem_ack = 1'b0;
        tick();
        check("b2b_idle", 64'(o_stall), 64'd0);
        check("stat_miss",  64'(o_miss_cnt),  STATS ? 64'd4 : 64'd0);
        check("stat_evict", 64'(o_evict_cnt), STATS ? 64'd2 : 64'd0);

        // reset two cycles into a waiting fill
        i_cache_miss = 1'b1; i_miss_addr = 32'h0000_0400; i_evict = 1'b0;
        tick();
        tick(); tick();
        check("mid_req", 64'(o_mem_req), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req",   64'(o_mem_req), 64'd0);
        check("mid_rst_stall", 64'(o_stall), 64'd0);
        check("mid_rst_mcnt",  64'(o_miss_cnt), 64'd0);
        i_cache_miss = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 64'(o_stall), 64'd0);
        i_cache_miss = 1'b1; i_miss_addr = 32'h0001_2345; i_evict = 1'b0;
        tick();
        check("post_rst_addr", 64'(o_mem_addr), 64'h0001_2340);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_BEEF;
        tick();
        check("post_rst_resp", 64'(o_memory_response), 64'd1);
        check("post_rst_line", 64'(o_memory_line), 64'h0000_BEEF);
        check("post_rst_mcnt", 64'(o_miss_cnt), STATS ? 64'd1 : 64'd0);
        i_cache_miss = 1'b0; i_mem_ack = 1'b0;
        tick();

        // timeout: never ack
        i_cache_miss = 1'b1; i_miss_addr = 32'h0000_0800; i_evict = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("tmo_req",  64'(o_mem_req), 64'd1);
            check("tmo_flag", 64'(o_timeout), 64'd0);
            tick();
        end
        check("tmo_err_req",  64'(o_mem_req), 64'd0);
        check("tmo_err_flag", 64'(o_timeout), 64'd1);
        check("tmo_err_stl",  64'(o_stall), 64'd1);
        i_cache_miss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_mem_ack = 1'b1;
            tick();
            check("tmo_sticky", 64'(o_timeout), 64'd1);
            check("tmo_stall",  64'(o_stall), 64'd1);
            check("tmo_noreq",  64'(o_mem_req), 64'd0);
        end
        i_mem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check("tmo_rst_flag",  64'(o_timeout), 64'd0);
        check("tmo_rst_stall", 64'(o_stall), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
